// File: rtl/tt_memop_tracker.sv
// rtl/tt_memop_tracker.sv - in-order tracker for outstanding memops, sync-start/sync-end to commit.
// Optional build macro TT_MEMOP_TRACKER_ERR_EN enables the sticky o_err protocol checker.
module tt_memop_tracker #(
    parameter int DEPTH = 4,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic             i_store,
    input  logic             i_id_ex_rts,
    input  logic             i_ex_rtr,
    input  logic             i_last_uop,
    input  logic             i_lq_empty,
    input  logic             i_memop_sync_end,
    input  logic [TAG_W-1:0] i_sync_end_tag,
    output logic             o_memop_sync_start,
    output logic [TAG_W-1:0] o_sync_start_tag,
    output logic             o_completed_valid,
    output logic [TAG_W-1:0] o_completed_tag,
    output logic             o_completed_is_load,
    output logic             o_ovi_stall,
    output logic [TAG_W:0]   o_outstanding,
    output logic             o_err
);

    typedef enum logic [1:0] {
        SLOT_FREE    = 2'd0,
        SLOT_PREPARE = 2'd1,
        SLOT_BUSY    = 2'd2,
        SLOT_SYNCED  = 2'd3
    } slot_state_t;

    slot_state_t      state_q [DEPTH];
    slot_state_t      state_d [DEPTH];
    logic [DEPTH-1:0] is_load_q;
    logic [DEPTH-1:0] is_load_d;
    logic [DEPTH-1:0] got_se_q;
    logic [DEPTH-1:0] got_se_d;
    logic [DEPTH-1:0] se_vec;

    logic [TAG_W-1:0] alloc_ptr_q;
    logic [TAG_W-1:0] head_ptr_q;
    logic [TAG_W:0]   outstanding_q;
    logic [TAG_W:0]   outstanding_d;

    logic             fire;
    logic             full;
    logic             open_valid;
    logic             alloc;
    logic             close;
    logic             commit;

    assign fire   = (i_load | i_store) & i_id_ex_rts & i_ex_rtr;
    assign full   = (outstanding_q == (TAG_W+1)'(DEPTH));
    assign alloc  = fire & ~open_valid & ~full;
    assign close  = fire & open_valid & i_last_uop;
    assign commit = (state_q[head_ptr_q] == SLOT_SYNCED) & i_lq_empty;

    // Only one slot can ever sit in PREPARE, so any PREPARE slot is the open one.
    always_comb begin
        open_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (state_q[i] == SLOT_PREPARE) begin
                open_valid = 1'b1;
            end
        end
    end

    always_comb begin
        se_vec = '0;
        if (i_memop_sync_end) begin
            se_vec[i_sync_end_tag] = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            state_d[i]   = state_q[i];
            is_load_d[i] = is_load_q[i];
            got_se_d[i]  = got_se_q[i];
            if (alloc && (alloc_ptr_q == TAG_W'(i))) begin
                is_load_d[i] = i_load;
                got_se_d[i]  = se_vec[i];
                state_d[i]   = i_last_uop ? SLOT_BUSY : SLOT_PREPARE;
            end else if (commit && (head_ptr_q == TAG_W'(i))) begin
                state_d[i]   = SLOT_FREE;
                is_load_d[i] = 1'b0;
                got_se_d[i]  = 1'b0;
            end else begin
                case (state_q[i])
                    SLOT_PREPARE: begin
                        if (close) begin
                            state_d[i] = (got_se_q[i] | se_vec[i]) ? SLOT_SYNCED : SLOT_BUSY;
                        end else if (se_vec[i]) begin
                            got_se_d[i] = 1'b1;
                        end
                    end
                    SLOT_BUSY: begin
                        if (got_se_q[i] | se_vec[i]) begin
                            state_d[i] = SLOT_SYNCED;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_comb begin
        outstanding_d = outstanding_q;
        case ({alloc, commit})
            2'b10:   outstanding_d = outstanding_q + (TAG_W+1)'(1);
            2'b01:   outstanding_d = outstanding_q - (TAG_W+1)'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= SLOT_FREE;
            end
            is_load_q     <= '0;
            got_se_q      <= '0;
            alloc_ptr_q   <= '0;
            head_ptr_q    <= '0;
            outstanding_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= state_d[i];
            end
            is_load_q     <= is_load_d;
            got_se_q      <= got_se_d;
            outstanding_q <= outstanding_d;
            if (alloc) begin
                alloc_ptr_q <= alloc_ptr_q + TAG_W'(1);
            end
            if (commit) begin
                head_ptr_q <= head_ptr_q + TAG_W'(1);
            end
        end
    end

`ifdef TT_MEMOP_TRACKER_ERR_EN
    logic        err_q;
    logic        se_bad;
    slot_state_t se_state;

    // The slot being allocated this cycle is still FREE in registered state but is a legal target.
    assign se_state = state_q[i_sync_end_tag];
    assign se_bad   = i_memop_sync_end
                    & ((se_state == SLOT_FREE) | (se_state == SLOT_SYNCED))
                    & ~(alloc & (alloc_ptr_q == i_sync_end_tag));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            err_q <= 1'b0;
        end else if (se_bad || (fire && o_ovi_stall)) begin
            err_q <= 1'b1;
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

    assign o_memop_sync_start  = alloc & ~i_reset;
    assign o_sync_start_tag    = alloc_ptr_q;
    assign o_completed_valid   = commit & ~i_reset;
    assign o_completed_tag     = head_ptr_q;
    assign o_completed_is_load = is_load_q[head_ptr_q];
    assign o_ovi_stall         = full & ~open_valid;
    assign o_outstanding       = outstanding_q;

endmodule

// File: tb/tb_tt_memop_tracker.sv
// tb/tb_tt_memop_tracker.sv - scoreboard bench for tt_memop_tracker with directed memop sequences.
module tb_tt_memop_tracker;

    localparam int DEPTH = 4;
    localparam int TAG_W = 2;
`ifdef TT_MEMOP_TRACKER_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic             i_clk = 1'b0;
    logic             i_reset = 1'b1;
    logic             i_load = 1'b0;
    logic             i_store = 1'b0;
    logic             i_id_ex_rts = 1'b0;
    logic             i_ex_rtr = 1'b0;
    logic             i_last_uop = 1'b0;
    logic             i_lq_empty = 1'b1;
    logic             i_memop_sync_end = 1'b0;
    logic [TAG_W-1:0] i_sync_end_tag = '0;
    logic             o_memop_sync_start;
    logic [TAG_W-1:0] o_sync_start_tag;
    logic             o_completed_valid;
    logic [TAG_W-1:0] o_completed_tag;
    logic             o_completed_is_load;
    logic             o_ovi_stall;
    logic [TAG_W:0]   o_outstanding;
    logic             o_err;

    tt_memop_tracker #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .i_clk               (i_clk),
        .i_reset             (i_reset),
        .i_load              (i_load),
        .i_store             (i_store),
        .i_id_ex_rts         (i_id_ex_rts),
        .i_ex_rtr            (i_ex_rtr),
        .i_last_uop          (i_last_uop),
        .i_lq_empty          (i_lq_empty),
        .i_memop_sync_end    (i_memop_sync_end),
        .i_sync_end_tag      (i_sync_end_tag),
        .o_memop_sync_start  (o_memop_sync_start),
        .o_sync_start_tag    (o_sync_start_tag),
        .o_completed_valid   (o_completed_valid),
        .o_completed_tag     (o_completed_tag),
        .o_completed_is_load (o_completed_is_load),
        .o_ovi_stall         (o_ovi_stall),
        .o_outstanding       (o_outstanding),
        .o_err               (o_err)
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [TAG_W-1:0] exp_start_q [$];
    logic [TAG_W:0]   exp_commit_q [$];
    logic [TAG_W-1:0] mon_start;
    logic [TAG_W:0]   mon_commit;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every presented sync-start or commit must match the head of its expectation queue.
    always @(negedge i_clk) begin
        if (o_memop_sync_start === 1'b1) begin
            if (exp_start_q.size() == 0) begin
                check("unexpected_sync_start", 32'(o_memop_sync_start), 32'd0);
            end else begin
                mon_start = exp_start_q.pop_front();
                check("sync_start_tag", 32'(o_sync_start_tag), 32'(mon_start));
            end
        end
        if (o_completed_valid === 1'b1) begin
            if (exp_commit_q.size() == 0) begin
                check("unexpected_commit", 32'(o_completed_valid), 32'd0);
            end else begin
                mon_commit = exp_commit_q.pop_front();
                check("commit_tag_is_load", 32'({o_completed_is_load, o_completed_tag}), 32'(mon_commit));
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
        i_load           = 1'b0;
        i_store          = 1'b0;
        i_id_ex_rts      = 1'b0;
        i_ex_rtr         = 1'b0;
        i_last_uop       = 1'b0;
        i_memop_sync_end = 1'b0;
        i_sync_end_tag   = '0;
    endtask

    task automatic drive_fire(input logic ld, input logic last);
        i_load      = ld;
        i_store     = ~ld;
        i_id_ex_rts = 1'b1;
        i_ex_rtr    = 1'b1;
        i_last_uop  = last;
    endtask

    task automatic drive_sync_end(input logic [TAG_W-1:0] tag);
        i_memop_sync_end = 1'b1;
        i_sync_end_tag   = tag;
    endtask

    task automatic exp_start(input logic [TAG_W-1:0] tag);
        exp_start_q.push_back(tag);
    endtask

    task automatic exp_commit(input logic [TAG_W-1:0] tag, input logic ld);
        exp_commit_q.push_back({ld, tag});
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        tick();
        tick();
        i_reset = 1'b0;
    endtask

    initial begin
        // Reset state, with a fire driven while reset is held
        drive_fire(1'b1, 1'b1);
        #2;
        check("rst_sync_start", 32'(o_memop_sync_start), 32'd0);
        tick();
        tick();
        check("rst_outstanding", 32'(o_outstanding), 32'd0);
        check("rst_completed_valid", 32'(o_completed_valid), 32'd0);
        check("rst_stall", 32'(o_ovi_stall), 32'd0);
        check("rst_start_tag", 32'(o_sync_start_tag), 32'd0);
        check("rst_completed_tag", 32'(o_completed_tag), 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        i_reset = 1'b0;

        // Single load, 3 uops; rts without rtr is not a fire
        drive_fire(1'b1, 1'b0);
        i_ex_rtr = 1'b0;
        tick();
        check("no_fire_outstanding", 32'(o_outstanding), 32'd0);
        drive_fire(1'b1, 1'b0); exp_start(2'd0); tick();
        check("t1_outstanding_1", 32'(o_outstanding), 32'd1);
        drive_fire(1'b1, 1'b0); tick();
        drive_fire(1'b1, 1'b1); tick();
        tick();
        drive_sync_end(2'd0); exp_commit(2'd0, 1'b1); tick();
        check("t1_commit_valid", 32'(o_completed_valid), 32'd1);
        check("t1_commit_is_load", 32'(o_completed_is_load), 32'd1);
        tick();
        check("t1_outstanding_0", 32'(o_outstanding), 32'd0);
        check("t1_valid_low", 32'(o_completed_valid), 32'd0);

        // Out-of-order sync_end: commits stay in allocation order
        do_reset();
        drive_fire(1'b0, 1'b1); exp_start(2'd0); tick();
        drive_fire(1'b1, 1'b1); exp_start(2'd1); tick();
        check("t2_outstanding_2", 32'(o_outstanding), 32'd2);
        drive_sync_end(2'd1); tick();
        check("t2_no_commit_a", 32'(o_completed_valid), 32'd0);
        tick();
        tick();
        check("t2_no_commit_b", 32'(o_completed_valid), 32'd0);
        drive_sync_end(2'd0); exp_commit(2'd0, 1'b0); exp_commit(2'd1, 1'b1); tick();
        check("t2_commit0_valid", 32'(o_completed_valid), 32'd1);
        check("t2_commit0_tag", 32'(o_completed_tag), 32'd0);
        tick();
        check("t2_commit1_valid", 32'(o_completed_valid), 32'd1);
        check("t2_commit1_tag", 32'(o_completed_tag), 32'd1);
        tick();
        check("t2_outstanding_0", 32'(o_outstanding), 32'd0);

        // Fill to DEPTH, overflow fire, commit while full gives no bypass
        do_reset();
        for (int k = 0; k < DEPTH; k++) begin
            drive_fire(1'b0, 1'b1); exp_start(TAG_W'(k)); tick();
        end
        check("t3_outstanding_full", 32'(o_outstanding), 32'd4);
        check("t3_stall", 32'(o_ovi_stall), 32'd1);
        check("t3_err_before", 32'(o_err), 32'd0);
        drive_fire(1'b0, 1'b1);
        #1;
        check("t3_overflow_no_start", 32'(o_memop_sync_start), 32'd0);
        tick();
        check("t3_err_after", 32'(o_err), 32'(ERR_EN));
        check("t3_outstanding_held", 32'(o_outstanding), 32'd4);
        drive_sync_end(2'd0); tick();
        exp_commit(2'd0, 1'b0);
        drive_fire(1'b0, 1'b1);
        #1;
        check("t3_full_commit_valid", 32'(o_completed_valid), 32'd1);
        check("t3_no_bypass", 32'(o_memop_sync_start), 32'd0);
        tick();
        check("t3_outstanding_3", 32'(o_outstanding), 32'd3);
        check("t3_stall_clear", 32'(o_ovi_stall), 32'd0);
        drive_fire(1'b0, 1'b1); exp_start(2'd0); tick();
        check("t3_outstanding_refill", 32'(o_outstanding), 32'd4);
        do_reset();
        check("t3_err_cleared", 32'(o_err), 32'd0);
        check("t3_rst_outstanding", 32'(o_outstanding), 32'd0);

        // Early sync_end while PREPARE; alloc and commit in the same cycle
        drive_fire(1'b1, 1'b0); exp_start(2'd0); tick();
        drive_sync_end(2'd0); tick();
        tick();
        drive_fire(1'b1, 1'b1); exp_commit(2'd0, 1'b1); tick();
        check("t4_commit_valid", 32'(o_completed_valid), 32'd1);
        check("t4_commit_tag", 32'(o_completed_tag), 32'd0);
        drive_fire(1'b0, 1'b1); exp_start(2'd1); tick();
        check("t4_alloc_commit_outstanding", 32'(o_outstanding), 32'd1);
        check("t4_valid_low", 32'(o_completed_valid), 32'd0);

        // Load queue not empty holds the commit back
        i_lq_empty = 1'b0;
        drive_sync_end(2'd1); tick();
        for (int k = 0; k < 5; k++) begin
            check("t5_lq_hold", 32'(o_completed_valid), 32'd0);
            tick();
        end
        i_lq_empty = 1'b1;
        exp_commit(2'd1, 1'b0);
        #1;
        check("t5_lq_release_valid", 32'(o_completed_valid), 32'd1);
        check("t5_lq_release_tag", 32'(o_completed_tag), 32'd1);
        tick();
        check("t5_outstanding_0", 32'(o_outstanding), 32'd0);

        // Reset asserted mid-operation
        drive_fire(1'b1, 1'b0); exp_start(2'd2); tick();
        check("t5_outstanding_1", 32'(o_outstanding), 32'd1);
        #2;
        i_reset = 1'b1;
        #1;
        check("midrst_outstanding", 32'(o_outstanding), 32'd0);
        check("midrst_start_tag", 32'(o_sync_start_tag), 32'd0);
        drive_fire(1'b1, 1'b1);
        #1;
        check("midrst_no_start", 32'(o_memop_sync_start), 32'd0);
        tick();
        i_reset = 1'b0;
        drive_fire(1'b0, 1'b1); exp_start(2'd0); tick();
        check("postrst_outstanding", 32'(o_outstanding), 32'd1);
        drive_sync_end(2'd3); tick();
        check("free_sync_end_err", 32'(o_err), 32'(ERR_EN));

        tick();
        tick();
        check("start_queue_drained", 32'(exp_start_q.size()), 32'd0);
        check("commit_queue_drained", 32'(exp_commit_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tt_memop_tracker.md
TT_MEMOP_TRACKER -- requirements
Module: tt_memop_tracker

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the maximum number of outstanding memops; legal values 2, 4 or 8.
REQ-002 SHALL have parameter TAG_W, default $clog2(DEPTH), meaning the slot tag width.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port i_reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have inputs i_load, i_store, i_id_ex_rts, i_ex_rtr, i_last_uop, i_lq_empty and i_memop_sync_end, each 1 bit, carrying memop uop qualifiers, handshake, last uop, load-queue empty and sync-end pulse.
REQ-006 SHALL have input i_sync_end_tag, TAG_W bits: the tag of the slot that i_memop_sync_end closes.
REQ-007 SHALL have outputs o_memop_sync_start (1 bit) and o_sync_start_tag (TAG_W): the sync-start pulse and the tag allocated to the new memop.
REQ-008 SHALL have outputs o_completed_valid, o_completed_tag (TAG_W) and o_completed_is_load: the commit pulse, its tag and the memop type.
REQ-009 SHALL have outputs o_ovi_stall (1), o_outstanding (TAG_W+1) and o_err (1): stall, allocated-slot count and sticky protocol error.

Function
REQ-010 A fire SHALL be defined as (i_load|i_store) & i_id_ex_rts & i_ex_rtr.
REQ-011 Each slot SHALL hold a 2-bit state (FREE, PREPARE, BUSY, SYNCED), an is_load bit and a got_sync_end bit; slots SHALL be allocated at alloc_ptr and retired at head_ptr, both wrapping modulo DEPTH.
REQ-012 At most one slot SHALL be "open" (in PREPARE) at any time.
REQ-013 A fire with no open slot and not full SHALL allocate slot alloc_ptr.
  - o_memop_sync_start=1 combinationally with o_sync_start_tag=alloc_ptr.
  - is_load <= i_load.
  - Next state PREPARE if !i_last_uop, else BUSY.
  - alloc_ptr increments.
REQ-014 A fire while a slot is open SHALL NOT allocate; if i_last_uop, the open slot SHALL move to BUSY, or directly to SYNCED if its got_sync_end is set or a matching sync_end arrives in the same cycle.
REQ-015 i_memop_sync_end SHALL affect the slot addressed by i_sync_end_tag.
  - BUSY: moves to SYNCED next cycle.
  - PREPARE, or the slot being allocated in this cycle: sets got_sync_end.
  - FREE or SYNCED: no state change; sets o_err.
REQ-016 A slot in BUSY with got_sync_end set SHALL move to SYNCED on the next cycle.
REQ-017 o_completed_valid SHALL be combinational: 1 when slot head_ptr is SYNCED and i_lq_empty=1.
  - o_completed_tag=head_ptr; o_completed_is_load = that slot's is_load.
  - On that edge the slot SHALL become FREE, its flags clear, and head_ptr increments.
  - Latency: sync_end at edge t gives o_completed_valid in cycle t+1 when the slot is head and i_lq_empty=1.
REQ-018 Commits SHALL be strictly in allocation order; a SYNCED non-head slot SHALL wait.
REQ-019 full SHALL be o_outstanding==DEPTH, computed from registered state; a commit in the same cycle SHALL NOT permit allocation (no bypass).
REQ-020 o_ovi_stall SHALL be full & no open slot.
  - A fire in that condition SHALL be ignored and SHALL set o_err.
REQ-021 o_outstanding SHALL equal allocations minus commits, updated each edge; simultaneous allocate and commit SHALL leave it unchanged.

Reset
REQ-022 Asserting i_reset, at any time including mid-operation, SHALL asynchronously set all slots to FREE, clear all flags, set both pointers and o_outstanding to 0, and set o_err=0.
REQ-023 During reset, o_memop_sync_start, o_completed_valid and o_ovi_stall SHALL be 0, and both tag outputs SHALL be 0.
REQ-024 Deassertion SHALL be synchronised externally; the first fire after deassertion SHALL allocate tag 0.

Configuration
REQ-025 With macro TT_MEMOP_TRACKER_ERR_EN defined, the o_err sticky logic of REQ-015/REQ-020 SHALL be built; o_err clears only on reset.
REQ-026 Without TT_MEMOP_TRACKER_ERR_EN, o_err SHALL be tied to 0 and no error state SHALL exist; all other behaviour SHALL be identical.

Verification
REQ-027 Single load, 3 uops (last on the 3rd fire), sync_end tag 0 two cycles later, i_lq_empty=1: response is sync_start tag 0 once, then o_completed_valid with tag 0 and is_load=1 one cycle after sync_end; o_outstanding goes 1 then 0.
REQ-028 DEPTH=4, four single-uop stores back-to-back with no sync_end: response is tags 0..3, o_outstanding=4, o_ovi_stall=1; a 5th fire is ignored and o_err=1 (macro on).
REQ-029 Two memops, sync_end tag 1 before tag 0, i_lq_empty=1: response is no commit until tag 0 syncs, then commits of tag 0 and tag 1 on consecutive cycles.
REQ-030 Sync_end for tag 0 arrives while slot 0 is still in PREPARE, last uop 2 cycles later: response is slot 0 going to SYNCED on last-uop acceptance and o_completed_valid on the next cycle.
REQ-031 Slot SYNCED with i_lq_empty=0 for 5 cycles: response is o_completed_valid held at 0 for those cycles, asserting in the cycle i_lq_empty rises; then i_reset pulsed mid-operation forces o_outstanding=0 and the next fire gets tag 0.
